// File: rtl/tictactoe_pkg.sv
// rtl/tictactoe_pkg.sv - player codes, FSM states and win-line table for the game controller
package tictactoe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        PX    = 2'b01,
        PO    = 2'b10
    } player_t;

    typedef enum logic [1:0] {
        PLAY  = 2'b00,
        CHECK = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int NUM_LINES = 8;

    // Each entry holds three square numbers (1..9) forming one winning line.
    localparam logic [NUM_LINES-1:0][2:0][3:0] LINE_TABLE = {
        4'd1, 4'd2, 4'd3,
        4'd4, 4'd5, 4'd6,
        4'd7, 4'd8, 4'd9,
        4'd1, 4'd4, 4'd7,
        4'd2, 4'd5, 4'd8,
        4'd3, 4'd6, 4'd9,
        4'd1, 4'd5, 4'd9,
        4'd3, 4'd5, 4'd7
    };

    function automatic logic [1:0] square_at(input logic [17:0] b, input logic [3:0] pos);
        square_at = EMPTY;
        for (int n = 1; n <= 9; n++) begin
            if (pos == 4'(n)) square_at = b[2*n-2 +: 2];
        end
    endfunction

    function automatic logic [1:0] other_player(input logic [1:0] p);
        return (p == PX) ? PO : PX;
    endfunction

endpackage

// File: rtl/line_checker.sv
// rtl/line_checker.sv - combinational scan of all eight lines for three equal non-empty codes
module line_checker
    import tictactoe_pkg::*;
(
    input  logic [17:0] board_i,
    output logic        win_o,
    output logic [1:0]  winner_o
);

    function automatic logic [1:0] line_owner(input logic [17:0] b, input int unsigned i);
        logic [1:0] a;
        logic [1:0] c;
        logic [1:0] d;
        a = square_at(b, LINE_TABLE[i][0]);
        c = square_at(b, LINE_TABLE[i][1]);
        d = square_at(b, LINE_TABLE[i][2]);
        return (a != EMPTY && a == c && c == d) ? a : EMPTY;
    endfunction

    always_comb begin
        win_o    = 1'b0;
        winner_o = EMPTY;
        for (int unsigned i = 0; i < NUM_LINES; i++) begin
            if (line_owner(board_i, i) != EMPTY) begin
                win_o    = 1'b1;
                winner_o = line_owner(board_i, i);
            end
        end
    end

endmodule

// File: rtl/game_controller.sv
// rtl/game_controller.sv - tic-tac-toe move controller with win/draw detection and turn timeout
module game_controller
    import tictactoe_pkg::*;
#(
    parameter logic [1:0]  FIRST_PLAYER = 2'b01,
    parameter int unsigned TIMEOUT      = 100000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        move_valid,
    input  logic [3:0]  move_pos,
    output logic        move_ready,
    input  logic        new_game,
    output logic [17:0] board,
    output logic [1:0]  turn,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic        draw,
    output logic        illegal,
    output logic        forfeit
);

    localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT) - 32'd1;

    state_t      state_q;
    logic [17:0] board_q;
    logic [17:0] board_d;
    logic [1:0]  turn_q;
    logic [1:0]  winner_q;
    logic [3:0]  move_cnt_q;
    logic [31:0] idle_q;
    logic        game_over_q;
    logic        draw_q;
    logic        illegal_q;
    logic        forfeit_q;

    logic        accept;
    logic        legal;
    logic        timeout_hit;
    logic        line_win;
    logic [1:0]  line_winner;

    line_checker u_line_checker (
        .board_i  (board_q),
        .win_o    (line_win),
        .winner_o (line_winner)
    );

    // Gated by reset so the port reads 0 for the whole time reset is held.
    assign move_ready  = (state_q == PLAY) && !reset;
    assign accept      = move_valid && move_ready;
    assign legal       = (move_pos >= 4'd1) && (move_pos <= 4'd9)
                         && (square_at(board_q, move_pos) == EMPTY);
    assign timeout_hit = (TIMEOUT != 0) && (idle_q == IDLE_LAST);

    always_comb begin
        board_d = board_q;
        for (int n = 1; n <= 9; n++) begin
            if (move_pos == 4'(n)) board_d[2*n-2 +: 2] = turn_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || new_game) begin
            state_q     <= PLAY;
            board_q     <= '0;
            turn_q      <= FIRST_PLAYER;
            move_cnt_q  <= '0;
            idle_q      <= '0;
            game_over_q <= 1'b0;
            winner_q    <= EMPTY;
            draw_q      <= 1'b0;
            illegal_q   <= 1'b0;
            forfeit_q   <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            forfeit_q <= 1'b0;
            case (state_q)
                PLAY: begin
                    // An accepted move outranks a timeout landing on the same edge.
                    if (accept) begin
                        idle_q <= '0;
                        if (legal) begin
                            board_q    <= board_d;
                            move_cnt_q <= (move_cnt_q >= 4'd9) ? 4'd9 : move_cnt_q + 4'd1;
                            state_q    <= CHECK;
                        end else begin
                            illegal_q <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        forfeit_q <= 1'b1;
                        turn_q    <= other_player(turn_q);
                        idle_q    <= '0;
                    end else begin
                        idle_q <= idle_q + 32'd1;
                    end
                end
                CHECK: begin
                    if (line_win) begin
                        state_q     <= DONE;
                        game_over_q <= 1'b1;
                        winner_q    <= line_winner;
                    end else if (move_cnt_q == 4'd9) begin
                        state_q     <= DONE;
                        game_over_q <= 1'b1;
                        draw_q      <= 1'b1;
                    end else begin
                        turn_q  <= other_player(turn_q);
                        state_q <= PLAY;
                    end
                end
                DONE: begin
                end
                default: state_q <= PLAY;
            endcase
        end
    end

    assign board     = board_q;
    assign turn      = turn_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;
    assign draw      = draw_q;
    assign illegal   = illegal_q;
    assign forfeit   = forfeit_q;

endmodule

// File: tb/tb_game_controller.sv
// tb/tb_game_controller.sv - directed and random game sequences checked against a square-array model
module tb_game_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        move_valid;
    logic [3:0]  move_pos;
    logic        move_ready;
    logic        new_game;
    logic [17:0] board;
    logic [1:0]  turn;
    logic        game_over;
    logic [1:0]  winner;
    logic        draw;
    logic        illegal;
    logic        forfeit;

    always #5 clk = ~clk;

    game_controller #(
        .FIRST_PLAYER (2'b01),
        .TIMEOUT      (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .move_valid (move_valid),
        .move_pos   (move_pos),
        .move_ready (move_ready),
        .new_game   (new_game),
        .board      (board),
        .turn       (turn),
        .game_over  (game_over),
        .winner     (winner),
        .draw       (draw),
        .illegal    (illegal),
        .forfeit    (forfeit)
    );

    int passed = 0;
    int total  = 0;

    // Model: bd[n] holds the player number (0 empty, 1 X, 2 O) on square n.
    int bd[10];
    int m_turn, m_n, m_over, m_win, m_draw;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int n = 0; n < 10; n++) bd[n] = 0;
        m_turn = 1;
        m_n    = 0;
        m_over = 0;
        m_win  = 0;
        m_draw = 0;
    endtask

    function automatic int model_winner();
        for (int r = 0; r < 3; r++) begin
            if (bd[3*r+1] != 0 && bd[3*r+1] == bd[3*r+2] && bd[3*r+2] == bd[3*r+3]) return bd[3*r+1];
        end
        for (int c = 1; c <= 3; c++) begin
            if (bd[c] != 0 && bd[c] == bd[c+3] && bd[c+3] == bd[c+6]) return bd[c];
        end
        if (bd[5] != 0 && bd[1] == bd[5] && bd[5] == bd[9]) return bd[5];
        if (bd[5] != 0 && bd[3] == bd[5] && bd[5] == bd[7]) return bd[5];
        return 0;
    endfunction

    function automatic logic [17:0] model_board();
        logic [17:0] v;
        int          code;
        v = '0;
        for (int n = 1; n <= 9; n++) begin
            code = bd[n];
            v[2*n-2 +: 2] = code[1:0];
        end
        return v;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_board"}, board, model_board());
        chk({tag, "_turn"}, turn, m_turn);
        chk({tag, "_over"}, game_over, m_over);
        chk({tag, "_winner"}, winner, m_win);
        chk({tag, "_draw"}, draw, m_draw);
    endtask

    task automatic do_move(input int pos);
        int legal;
        chk("ready_pre", move_ready, (m_over != 0) ? 0 : 1);
        move_valid = 1'b1;
        move_pos   = pos[3:0];
        tick();
        move_valid = 1'b0;
        if (m_over != 0) begin
            chk("done_no_illegal", illegal, 0);
            check_state("done");
            return;
        end
        legal = (pos >= 1 && pos <= 9) ? ((bd[pos] == 0) ? 1 : 0) : 0;
        chk("no_forfeit", forfeit, 0);
        if (legal == 0) begin
            chk("illegal_pulse", illegal, 1);
            chk("illegal_ready", move_ready, 1);
            check_state("illegal");
            tick();
            chk("illegal_clear", illegal, 0);
        end else begin
            bd[pos] = m_turn;
            m_n++;
            chk("legal_no_illegal", illegal, 0);
            chk("check_ready", move_ready, 0);
            check_state("check");
            tick();
            if (model_winner() != 0) begin
                m_over = 1;
                m_win  = model_winner();
            end else if (m_n == 9) begin
                m_over = 1;
                m_draw = 1;
            end else begin
                m_turn = 3 - m_turn;
            end
            check_state("post");
            chk("post_ready", move_ready, (m_over != 0) ? 0 : 1);
        end
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        model_reset();
        check_state("newgame");
        chk("newgame_ready", move_ready, 1);
    endtask

    task automatic play_seq(input int seq[$]);
        foreach (seq[i]) do_move(seq[i]);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_forfeit;
        int forfeit_cnt;
        int pos;
        int steps;
        int empt[$];

        reset      = 1'b1;
        move_valid = 1'b0;
        move_pos   = 4'd0;
        new_game   = 1'b0;
        model_reset();
        repeat (3) tick();
        chk("rst_ready", move_ready, 0);
        check_state("rst");
        chk("rst_illegal", illegal, 0);
        chk("rst_forfeit", forfeit, 0);
        reset = 1'b0;
        #1;
        chk("rst_release_ready", move_ready, 1);

        // Row win for X.
        play_seq('{1, 4, 2, 5, 3});
        chk("row_win_over", game_over, 1);
        chk("row_win_winner", winner, 2'b01);
        chk("row_win_ready", move_ready, 0);
        do_move(7);
        do_move(8);

        pulse_new_game();
        do_move(1);
        do_move(1);
        chk("occupied_board", board, 18'h00001);
        chk("occupied_turn", turn, 2'b10);
        do_move(0);
        do_move(12);
        do_move(15);

        pulse_new_game();
        play_seq('{1, 2, 3, 5, 4, 6, 8, 7, 9});
        chk("draw_flag", draw, 1);
        chk("draw_winner", winner, 2'b00);
        chk("draw_over", game_over, 1);

        pulse_new_game();
        play_seq('{1, 2, 5, 3, 6, 4, 8, 7, 9});
        chk("ninth_win_winner", winner, 2'b01);
        chk("ninth_win_draw", draw, 0);

        // Reset mid-game discards the board.
        pulse_new_game();
        do_move(1);
        do_move(2);
        reset = 1'b1;
        tick();
        model_reset();
        chk("midreset_ready", move_ready, 0);
        check_state("midreset");
        reset = 1'b0;
        #1;
        chk("midreset_release_ready", move_ready, 1);

        // Reset landing while the FSM sits in CHECK.
        move_valid = 1'b1;
        move_pos   = 4'd5;
        tick();
        move_valid = 1'b0;
        chk("pre_check_ready", move_ready, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check_state("checkreset");
        chk("checkreset_illegal", illegal, 0);
        chk("checkreset_forfeit", forfeit, 0);
        chk("checkreset_ready", move_ready, 1);

        // new_game beats a simultaneous move.
        new_game   = 1'b1;
        move_valid = 1'b1;
        move_pos   = 4'd5;
        tick();
        new_game   = 1'b0;
        move_valid = 1'b0;
        model_reset();
        check_state("ng_prio");
        chk("ng_prio_illegal", illegal, 0);

        // Turn timeout after ten idle PLAY cycles.
        pulse_new_game();
        first_forfeit = 0;
        forfeit_cnt   = 0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (forfeit === 1'b1) begin
                forfeit_cnt++;
                if (first_forfeit == 0) first_forfeit = k;
            end
        end
        chk("forfeit_cycle", first_forfeit, 10);
        chk("forfeit_width", forfeit_cnt, 1);
        m_turn = 2;
        check_state("forfeit");
        do_move(0);

        // A move on the timeout cycle wins over the forfeit.
        pulse_new_game();
        repeat (9) tick();
        do_move(5);
        chk("move_vs_timeout_turn", turn, 2'b10);

        pulse_new_game();
        play_seq('{1, 2});
        pulse_new_game();
        play_seq('{3, 1, 5, 2, 7});
        chk("diag_win_winner", winner, 2'b01);
        pulse_new_game();
        do_move(9);
        chk("resume_board", board, 18'h10000);

        for (int g = 0; g < 10; g++) begin
            pulse_new_game();
            steps = 0;
            while (m_over == 0 && steps < 80) begin
                if (steps < 40 && $urandom_range(0, 3) == 0) begin
                    pos = int'($urandom_range(0, 15));
                end else begin
                    empt.delete();
                    for (int n = 1; n <= 9; n++) if (bd[n] == 0) empt.push_back(n);
                    pos = empt[$urandom_range(0, empt.size() - 1)];
                end
                do_move(pos);
                steps++;
            end
            chk("rnd_finished", game_over, 1);
            do_move(int'($urandom_range(1, 9)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
